add_accumulator: RTL
====================

# add_accumulator

Streaming frame accumulator that sits directly upstream of the carry-lookahead `Adder` stage. It accepts signed samples over a valid/ready handshake and feeds the running total and each new sample into `Adder` as its two operands. It registers the `Adder` result back as the new total and applies signed-overflow handling. When a frame completes, it presents the total with its sample count and an overflow flag on a valid/ready output.

## Interface
- `DATA_WIDTH`, 16: sample, accumulator and result width; must be a multiple of 4.
- `FRAME_LEN`, 8: maximum number of samples per frame; must be ≥ 1.
- `CNT_W`, `$clog2(FRAME_LEN+1)`: count width. Derived; not overridden.
- `clk` in 1: the only clock; all state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: sample valid.
- `in_ready` out 1: block can accept a sample.
- `in_data` in `DATA_WIDTH`: signed sample.
- `in_last` in 1: sample is the final one of the frame. Qualified by the handshake.
- `out_valid` out 1: frame result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out `DATA_WIDTH`: signed frame total.
- `out_count` out `CNT_W`: number of samples in the frame.
- `out_ovf` out 1: one or more overflows occurred during the frame.

## Operation
- States:
  - IDLE: no samples held; accumulator is 0.
  - ACCUM: one or more samples accepted.
  - HOLD: result presented.
- Handshakes:
  - `in_ready` = (state != HOLD). `out_valid` = (state == HOLD).
  - An input handshake is `in_valid && in_ready`.
  - An output handshake is `out_valid && out_ready`.
- Add path, per input handshake:
  - `Adder` operands: `a` = accumulator, which is 0 in IDLE; `b` = `in_data`; `cin` = 0.
  - Overflow = (`a`[MSB] == `b`[MSB]) && (`sum`[MSB] != `a`[MSB]).
  - On overflow, the sticky `ovf` is set. The value written to the accumulator is set by `ADD_ACCUM_SATURATE_EN`.
  - `cout` is ignored.
- Count:
  - `count` increments on each input handshake.
  - The frame ends on a handshake where `in_last` = 1 or the new count == `FRAME_LEN`.
- Transitions:
  - IDLE → ACCUM on a handshake that does not end the frame.
  - IDLE/ACCUM → HOLD on a handshake that ends the frame. Accumulator, count and `ovf` are latched into the output registers.
  - HOLD → IDLE on an output handshake. Accumulator, count and `ovf` are cleared.
- Outputs:
  - Output registers stay stable while `out_valid` = 1.
  - `out_sum`, `out_count` and `out_ovf` are 0 outside HOLD.
- A frame of one sample is legal: `in_last` on the first sample gives `out_count` = 1.

## Timing
- Reset values: state IDLE; `in_ready` = 1; `out_valid`, `out_sum`, `out_count` and `out_ovf` all 0; accumulator, count and `ovf` all 0.
- Latency: `out_valid` rises on the clock edge that captures the frame's final sample, so it is visible in the next cycle.
- `Adder` is combinational; the add and the write-back complete in one cycle. Throughput is one sample per cycle within a frame.
- HOLD lasts at least 1 cycle, so the minimum frame period is samples + 1 cycles.
- `in_valid` while in HOLD is not accepted; the upstream must hold its data.
- `out_ready` while not in HOLD is ignored.
- Reset asserted mid-frame or during HOLD: the partial frame or pending result is discarded. All registers take their reset values immediately.

## Configuration
- `ADD_ACCUM_SATURATE_EN` defined:
  - On overflow, the accumulator is clamped to the signed maximum (0x7FF…F) for positive overflow, or the signed minimum (0x800…0) for negative overflow.
  - Later samples add to the clamped value.
- Undefined: the accumulator takes the wrapped `Adder` sum.
- `out_ovf` is sticky per frame in both builds.

## Structure
- Package `add_accum_pkg`:
  - State enum typedef `add_accum_state_t` (IDLE/ACCUM/HOLD).
  - Functions `sat_max(width)` and `sat_min(width)`.
- Sub-module: one instance of the existing `Adder`, with `DATA_WIDTH` passed through. No other sub-modules.

## Test plan
All scenarios use `DATA_WIDTH` = 16 and `FRAME_LEN` = 4.
- Samples 1, 2, 3, 4 sent back-to-back, `out_ready` = 1 → `out_sum` = 10, `out_count` = 4, `out_ovf` = 0. `out_valid` is high in the cycle after the 4th sample, for exactly 1 cycle.
- 0x7000 then 0x2000 with `in_last` → `out_count` = 2, `out_ovf` = 1. `out_sum` = 0x7FFF with `_EN` defined, 0x9000 without.
- 0xA000 then 0xA000 with `in_last` → `out_ovf` = 1. `out_sum` = 0x8000 with `_EN` defined, 0x4000 without.
- 0x7000, 0x7000, 0xF000 with `in_last`, `_EN` defined → `out_sum` = 0x6FFF, `out_ovf` = 1.
- Frame 1, 1, 1, 1 with `out_ready` = 0 for 5 cycles while `in_valid` = 1:
  - `in_ready` = 0 and outputs are held at sum 4 / count 4.
  - The held input sample is accepted only after `out_ready` rises.
- `rst_n` pulsed low after 2 samples (5, 5), then a new frame 5, 5, 5, 5 → all outputs are 0 during reset, and the new frame gives `out_sum` = 20, `out_count` = 4.

Source files
------------

// File: rtl/add_accum_pkg.sv
// Shared types and saturation helpers for the add_accumulator frame accumulator.
package add_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } add_accum_state_t;

  localparam int SAT_FN_W = 64;

  // Helpers return a 64-bit value; callers cast down to their own width.
  function automatic logic [SAT_FN_W-1:0] sat_max(input int width);
    return (SAT_FN_W'(1) << (width - 1)) - SAT_FN_W'(1);
  endfunction

  function automatic logic [SAT_FN_W-1:0] sat_min(input int width);
    return SAT_FN_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/Adder.sv
// Carry-lookahead adder: 4-bit lookahead groups with the group carry rippled between groups.
module Adder #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);

  localparam int GROUPS = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] p;
  logic [DATA_WIDTH-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    logic carry;
    int   base;
    c     = '0;
    carry = cin;
    base  = 0;
    for (int k = 0; k < GROUPS; k++) begin
      base        = 4 * k;
      c[base]     = carry;
      c[base + 1] = g[base] | (p[base] & carry);
      c[base + 2] = g[base + 1] | (p[base + 1] & g[base])
                  | (p[base + 1] & p[base] & carry);
      c[base + 3] = g[base + 2] | (p[base + 2] & g[base + 1])
                  | (p[base + 2] & p[base + 1] & g[base])
                  | (p[base + 2] & p[base + 1] & p[base] & carry);
      carry       = g[base + 3] | (p[base + 3] & g[base + 2])
                  | (p[base + 3] & p[base + 2] & g[base + 1])
                  | (p[base + 3] & p[base + 2] & p[base + 1] & g[base])
                  | (p[base + 3] & p[base + 2] & p[base + 1] & p[base] & carry);
    end
    cout = carry;
  end

  assign sum = p ^ c;

endmodule

// File: rtl/add_accumulator.sv
// Streaming signed frame accumulator feeding Adder; presents total, count and sticky overflow per frame.
// Define ADD_ACCUM_SATURATE_EN to clamp the total on overflow instead of wrapping.
module add_accumulator
  import add_accum_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int FRAME_LEN  = 8,
  localparam int CNT_W      = $clog2(FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_ovf
);

  localparam int MSB = DATA_WIDTH - 1;

  add_accum_state_t      state;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] sum_q;
  logic [CNT_W-1:0]      count_q;
  logic                  ovf_q;

  logic [DATA_WIDTH-1:0] a_op;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  unused_cout;
  logic                  add_ovf;
  logic [DATA_WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  ovf_nxt;
  logic                  in_fire;
  logic                  frame_end;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign in_fire   = in_valid && in_ready;

  assign a_op = (state == IDLE) ? '0 : acc;

  Adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
    .a    (a_op),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (unused_cout)
  );

  // Signed overflow: operands agree in sign but the result does not.
  assign add_ovf = (a_op[MSB] == in_data[MSB]) && (add_sum[MSB] != a_op[MSB]);

`ifdef ADD_ACCUM_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));

  // A positive accumulator can only overflow upward, a negative one only downward.
  assign acc_nxt = !add_ovf ? add_sum : (a_op[MSB] ? SAT_MIN : SAT_MAX);
`else
  assign acc_nxt = add_sum;
`endif

  assign cnt_nxt   = cnt + CNT_W'(1);
  assign ovf_nxt   = ovf | add_ovf;
  assign frame_end = in_last || (cnt_nxt == CNT_W'(FRAME_LEN));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_fire) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            if (frame_end) begin
              state   <= HOLD;
              sum_q   <= acc_nxt;
              count_q <= cnt_nxt;
              ovf_q   <= ovf_nxt;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // Clearing the output registers here keeps the outputs at 0 outside HOLD.
          if (out_ready) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

endmodule
